// File: rtl/pz_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : pz_pkg                                                   |
// | Purpose  : Shared operation codes for the program-counter unit      |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package pz_pkg;

  localparam int MODUS_W = 3;

  localparam logic [MODUS_W-1:0] MODUS_INC    = 3'd0;
  localparam logic [MODUS_W-1:0] MODUS_JUMP   = 3'd1;
  localparam logic [MODUS_W-1:0] MODUS_BRANCH = 3'd2;
  localparam logic [MODUS_W-1:0] MODUS_CALL   = 3'd3;
  localparam logic [MODUS_W-1:0] MODUS_RET    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/programmzahler_einheit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : programmzahler_einheit_if                                |
// | Purpose  : Control-side bundle between control unit, PC unit and    |
// |            instruction fetch. master = control/fetch side,          |
// |            slave = program-counter unit.                            |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
interface programmzahler_einheit_if
  import pz_pkg::*;
#(
  parameter int WIDTH        = 26,
  parameter int OFFSET_WIDTH = 16,
  parameter int STACK_DEPTH  = 8
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic                    Halten;
  logic [MODUS_W-1:0]      Modus;
  logic [WIDTH-1:0]        Ziel;
  logic [OFFSET_WIDTH-1:0] Offset;
  logic [WIDTH-1:0]        AktuellerPC;
  logic [DEPTH_W-1:0]      StapelTiefe;
  logic                    Ueberlauf;
  logic                    Unterlauf;

  modport master (
    output Halten, Modus, Ziel, Offset,
    input  AktuellerPC, StapelTiefe, Ueberlauf, Unterlauf
  );

  modport slave (
    input  Halten, Modus, Ziel, Offset,
    output AktuellerPC, StapelTiefe, Ueberlauf, Unterlauf
  );

endinterface
`default_nettype wire

// File: rtl/programmzahler_einheit_ruecksprung_stapel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ruecksprung_stapel                                       |
// | Purpose  : Circular return-address stack. A push on a full stack    |
// |            overwrites the oldest entry; depth saturates.            |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module ruecksprung_stapel #(
  parameter int WIDTH       = 26,
  parameter int STACK_DEPTH = 8
) (
  input  wire logic                               TaktSignal,
  input  wire logic                               Reset,
  input  wire logic                               push,
  input  wire logic                               pop,
  input  wire logic [WIDTH-1:0]                   din,
  output logic      [WIDTH-1:0]                   dout,
  output logic      [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                                    full,
  output logic                                    empty
);
  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  // Circular indexing relies on the pointer wrapping naturally.
  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_depth_check
    $error("STACK_DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0]   mem_q [STACK_DEPTH];
  logic [PTR_W-1:0]   wp_q, wp_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;

  assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty = (depth_q == '0);
  assign depth = depth_q;
  assign dout  = mem_q[wp_q - PTR_W'(1)];

  // Pointer and depth bookkeeping; push wins if both are requested.
  always_comb begin
    wp_d    = wp_q;
    depth_d = depth_q;
    if (push) begin
      wp_d = wp_q + PTR_W'(1);
      if (!full) depth_d = depth_q + DEPTH_W'(1);
    end else if (pop && !empty) begin
      wp_d    = wp_q - PTR_W'(1);
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  // Pointer/depth registers, cleared asynchronously.
  always_ff @(posedge TaktSignal or posedge Reset) begin
    if (Reset) begin
      wp_q    <= '0;
      depth_q <= '0;
    end else begin
      wp_q    <= wp_d;
      depth_q <= depth_d;
    end
  end

  // Storage array; contents are meaningless after reset, so no clear.
  always_ff @(posedge TaktSignal) begin
    if (push) mem_q[wp_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/programmzahler_einheit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : programmzahler_einheit                                   |
// | Purpose  : Program counter with stall, jump, relative branch and    |
// |            call/return via a circular return-address stack.         |
// |            Define PZ_TRAP_EN to redirect stack errors to            |
// |            TRAP_VECTOR instead of overwrite / INC fallback.         |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module programmzahler_einheit
  import pz_pkg::*;
#(
  parameter int               WIDTH        = 26,
  parameter int               OFFSET_WIDTH = 16,
  parameter int               STACK_DEPTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 'h3FFFF00
) (
  input wire logic                TaktSignal,
  input wire logic                Reset,
  programmzahler_einheit_if.slave bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

`ifdef PZ_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [WIDTH-1:0]   pc_q, pc_d;
  logic               ueberlauf_q, ueberlauf_d;
  logic               unterlauf_q, unterlauf_d;
  logic [WIDTH-1:0]   pc_inc;
  logic [WIDTH-1:0]   offset_ext;
  logic               push, pop;
  logic [WIDTH-1:0]   stack_top;
  logic [DEPTH_W-1:0] stack_depth;
  logic               stack_full, stack_empty;

  assign pc_inc     = pc_q + WIDTH'(1);
  assign offset_ext = WIDTH'($signed(bus.Offset));

  ruecksprung_stapel #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stapel (
    .TaktSignal (TaktSignal),
    .Reset      (Reset),
    .push       (push),
    .pop        (pop),
    .din        (pc_inc),
    .dout       (stack_top),
    .depth      (stack_depth),
    .full       (stack_full),
    .empty      (stack_empty)
  );

  // Next-PC selection, stack requests and sticky error flags.
  always_comb begin
    pc_d        = pc_q;
    ueberlauf_d = ueberlauf_q;
    unterlauf_d = unterlauf_q;
    push        = 1'b0;
    pop         = 1'b0;
    if (!bus.Halten) begin
      case (bus.Modus)
        MODUS_JUMP:   pc_d = bus.Ziel;
        MODUS_BRANCH: pc_d = pc_q + offset_ext;
        MODUS_CALL: begin
          if (stack_full) ueberlauf_d = 1'b1;
          if (stack_full && TRAP_EN) begin
            pc_d = TRAP_VECTOR;
          end else begin
            // On a full stack without trapping, the oldest entry is lost.
            push = 1'b1;
            pc_d = bus.Ziel;
          end
        end
        MODUS_RET: begin
          if (stack_empty) begin
            unterlauf_d = 1'b1;
            pc_d        = TRAP_EN ? TRAP_VECTOR : pc_inc;
          end else begin
            pop  = 1'b1;
            pc_d = stack_top;
          end
        end
        default:      pc_d = pc_inc;  // INC and reserved codes
      endcase
    end
  end

  // PC and flag registers, cleared asynchronously.
  always_ff @(posedge TaktSignal or posedge Reset) begin
    if (Reset) begin
      pc_q        <= RESET_VECTOR;
      ueberlauf_q <= 1'b0;
      unterlauf_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ueberlauf_q <= ueberlauf_d;
      unterlauf_q <= unterlauf_d;
    end
  end

  assign bus.AktuellerPC = pc_q;
  assign bus.StapelTiefe = stack_depth;
  assign bus.Ueberlauf   = ueberlauf_q;
  assign bus.Unterlauf   = unterlauf_q;

endmodule
`default_nettype wire

// File: doc/programmzahler_einheit.md
Name: programmzahler_einheit

Overview:
Parametrised program-counter unit for the Hans processor core. It replaces the fixed 26-bit increment/load counter. It adds stall, absolute jump, PC-relative branch, and call/return through an internal circular return-address stack with depth tracking and sticky error flags. It sits between the control unit (which drives Modus) and instruction fetch (which consumes AktuellerPC).

Parameters:
WIDTH, 26, PC width in bits
OFFSET_WIDTH, 16, width of signed branch offset
STACK_DEPTH, 8, return-address stack entries (power of two, >=2)
RESET_VECTOR, 0, PC value after reset
TRAP_VECTOR, 'h3FFFF00, PC target on stack error (used only with PZ_TRAP_EN)

Ports:
TaktSignal  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high; clears all state
Halten  input  1  stall: when 1, all state holds and Modus is ignored
Modus  input  3  operation select (see Behaviour)
Ziel  input  WIDTH  absolute target for JUMP/CALL
Offset  input  OFFSET_WIDTH  signed two's-complement branch offset
AktuellerPC  output  WIDTH  registered current PC
StapelTiefe  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
Ueberlauf  output  1  sticky: CALL issued while stack full
Unterlauf  output  1  sticky: RET issued while stack empty

Behaviour:
- Reset is asynchronous and active-high. While it is asserted: AktuellerPC=RESET_VECTOR, stack pointer=0, StapelTiefe=0, Ueberlauf=0, Unterlauf=0. Stack RAM contents are don't-care. Reset mid-call discards the whole stack.
- All updates occur on the rising edge of TaktSignal when Reset=0 and Halten=0. AktuellerPC reflects the operation one cycle after the edge; there is no combinational path from inputs to outputs.
- Halten=1: PC, stack, depth and flags all hold, with no side effects from Modus.
- Modus encoding:
  - 0 INC: PC <= PC+1.
  - 1 JUMP: PC <= Ziel. The target is taken exactly, with no +1.
  - 2 BRANCH: PC <= PC + sign_extend(Offset). Sign-extend to WIDTH; the result is modulo 2^WIDTH.
  - 3 CALL: push PC+1, then PC <= Ziel.
  - 4 RET: PC <= popped entry.
  - 5-7 reserved: behave as INC.
- Arithmetic: all PC sums wrap modulo 2^WIDTH. PC = all-ones followed by INC gives 0.
- Stack: circular buffer with write pointer wp (log2 STACK_DEPTH bits, wraps) and depth counter StapelTiefe.
  - Push: mem[wp]<=value, wp<=wp+1, depth<=min(depth+1, STACK_DEPTH).
  - Pop: value=mem[wp-1], wp<=wp-1, depth<=depth-1.
- Overflow (CALL with depth==STACK_DEPTH): the push overwrites the oldest entry, depth stays at STACK_DEPTH, the jump to Ziel is taken, and Ueberlauf<=1.
- Underflow (RET with depth==0): PC <= PC+1, the stack is unchanged, and Unterlauf<=1.
- Ueberlauf and Unterlauf are sticky and cleared only by Reset.

Optional Feature:
PZ_TRAP_EN
- Defined:
  - CALL on a full stack does not push, depth and wp are unchanged, PC <= TRAP_VECTOR, and Ueberlauf<=1.
  - RET on an empty stack sets PC <= TRAP_VECTOR and Unterlauf<=1.
- Undefined: the overwrite and INC fallback described in Behaviour apply; TRAP_VECTOR is unused.

Decomposition:
- Shared package pz_pkg:
  - localparam mode constants MODUS_INC=3'd0, MODUS_JUMP=3'd1, MODUS_BRANCH=3'd2, MODUS_CALL=3'd3, MODUS_RET=3'd4.
  - Width localparam MODUS_W=3.
- Sub-module ruecksprung_stapel (parameters WIDTH, STACK_DEPTH):
  - Inputs: clock, Reset, push, pop, din.
  - Outputs: dout (top entry), depth, full, empty.
  - Implements the circular storage and pointer logic.
- Top level holds the PC register, next-PC mux and flags.

Test Plan:
- Reset, release, 5 cycles of INC -> AktuellerPC 0,1,2,3,4,5; assert Reset asynchronously mid-cycle -> AktuellerPC=0 immediately, no clock edge needed.
- PC=10, BRANCH Offset=-4 -> 6; PC=2^26-1, INC -> 0; JUMP Ziel=0x1234 -> 0x1234 with no +1.
- PC=0x100: CALL Ziel=0x200, then CALL Ziel=0x300, then RET, then RET -> PC sequence 0x200, 0x300, 0x201, 0x101; StapelTiefe 1,2,1,0.
- Issue STACK_DEPTH+1 CALLs (Ziel=k) -> Ueberlauf=1 and StapelTiefe=8. Without PZ_TRAP_EN, 8 RETs return the newest 8 return addresses. With PZ_TRAP_EN, the 9th CALL gives PC=TRAP_VECTOR.
- RET on empty stack at PC=0x50 -> PC=0x51 and Unterlauf=1 (PC=TRAP_VECTOR with PZ_TRAP_EN). Unterlauf stays 1 across later operations until Reset.
- Halten=1 for 3 cycles while Modus=CALL -> PC, StapelTiefe and flags unchanged; Halten=0 -> the CALL executes exactly once.
